// File: rtl/controller.sv
// Smart-parking central FSM: latches the system token, checks user tokens
// and steers time_data to register P (match) or Q (mismatch).
module controller #(
  parameter int TOKEN_W = 3,
  parameter int DATA_W  = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [TOKEN_W-1:0] system_token,
  input  logic               request,
  input  logic [DATA_W-1:0]  time_data,
  input  logic               confirm,
  input  logic [TOKEN_W-1:0] user_token,
  output logic [DATA_W-1:0]  data_to_save,
  output logic               enable_P,
  output logic               enable_Q
);

  typedef enum logic [2:0] {
    START           = 3'd0,
    ACTIVE          = 3'd1,
    REQUEST_PROCESS = 3'd2,
    STORE_P         = 3'd3,
    STORE_Q         = 3'd4
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [TOKEN_W-1:0] stored_token;

  always_comb begin
    next_state = state;
    unique case (state)
      START:  next_state = ACTIVE;
      ACTIVE: if (request) next_state = REQUEST_PROCESS;
      REQUEST_PROCESS: begin
        if (confirm)
          next_state = (user_token == stored_token) ? STORE_P : STORE_Q;
        else if (!request)
          next_state = ACTIVE;
      end
      STORE_P, STORE_Q: if (!confirm) next_state = ACTIVE;
      default: next_state = START;
    endcase
  end

  // Enables are registered from next_state so they equal a decode of state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= START;
      stored_token <= '0;
      enable_P     <= 1'b0;
      enable_Q     <= 1'b0;
    end else begin
      state    <= next_state;
      enable_P <= (next_state == STORE_P);
      enable_Q <= (next_state == STORE_Q);
      if (state == START) stored_token <= system_token;
    end
  end

  // Pass-through so late-arriving time_data is still captured.
  assign data_to_save = (enable_P || enable_Q) ? time_data : '0;

endmodule

// File: tb/tb_controller.sv
// Scoreboard bench for controller: expectations queued per driven cycle,
// popped and compared once the DUT has reacted to the clock edge.
module tb_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] system_token;
  logic       request;
  logic [7:0] time_data;
  logic       confirm;
  logic [2:0] user_token;
  logic [7:0] data_to_save;
  logic       enable_P;
  logic       enable_Q;

  localparam logic [2:0] S_START = 3'd0;
  localparam logic [2:0] S_ACT   = 3'd1;
  localparam logic [2:0] S_REQ   = 3'd2;
  localparam logic [2:0] S_P     = 3'd3;
  localparam logic [2:0] S_Q     = 3'd4;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic       p;
    logic       q;
    logic [7:0] d;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  controller dut (
    .clock        (clock),
    .reset        (reset),
    .system_token (system_token),
    .request      (request),
    .time_data    (time_data),
    .confirm      (confirm),
    .user_token   (user_token),
    .data_to_save (data_to_save),
    .enable_P     (enable_P),
    .enable_Q     (enable_Q)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic req,
                      input logic conf, input logic [2:0] ut,
                      input logic [2:0] sys, input logic [7:0] td,
                      input logic [2:0] est, input logic ep,
                      input logic eq, input logic [7:0] ed,
                      input logic late = 1'b0,
                      input logic [7:0] late_td = 8'h00);
    exp_t e;
    exp_t g;
    logic [2:0] st_obs;
    reset        = rst;
    request      = req;
    confirm      = conf;
    user_token   = ut;
    system_token = sys;
    time_data    = td;
    e.tag = tag; e.st = est; e.p = ep; e.q = eq; e.d = ed;
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (late) time_data = late_td;
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      g = sb.pop_front();
      st_obs = dut.state;
      check({g.tag, "_state"}, 32'(st_obs), 32'(g.st));
      check({g.tag, "_enP"}, 32'(enable_P), 32'(g.p));
      check({g.tag, "_enQ"}, 32'(enable_Q), 32'(g.q));
      check({g.tag, "_data"}, 32'(data_to_save), 32'(g.d));
      check({g.tag, "_excl"}, 32'(enable_P & enable_Q), 32'd0);
    end
    #3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; request = 1'b0; confirm = 1'b0;
    user_token = 3'b000; system_token = 3'b101; time_data = 8'h00;
    @(negedge clock);
    // reset then start
    step("rst",     1,0,0,3'b000,3'b101,8'h11, S_START,0,0,8'h00);
    step("start",   0,0,0,3'b000,3'b101,8'h22, S_ACT,  0,0,8'h00);
    step("idle",    0,0,0,3'b000,3'b101,8'h33, S_ACT,  0,0,8'h00);
    // accepted path with late time_data
    step("acc_req", 0,1,0,3'b000,3'b101,8'h00, S_REQ,  0,0,8'h00);
    step("acc_cf",  0,1,1,3'b101,3'b101,8'h00, S_P,    1,0,8'hF0,
         1'b1, 8'hF0);
    step("acc_end", 0,0,0,3'b101,3'b101,8'hF0, S_ACT,  0,0,8'h00);
    // rejected path; user token change in STORE_Q must not flip to P
    step("rej_req", 0,1,0,3'b000,3'b101,8'h00, S_REQ,  0,0,8'h00);
    step("rej_cf",  0,1,1,3'b011,3'b101,8'h3C, S_Q,    0,1,8'h3C);
    step("rej_hld", 0,1,1,3'b101,3'b101,8'h77, S_Q,    0,1,8'h77);
    step("rej_end", 0,0,0,3'b101,3'b101,8'h77, S_ACT,  0,0,8'h00);
    // withdrawal
    step("wd_req",  0,1,0,3'b000,3'b101,8'h99, S_REQ,  0,0,8'h00);
    step("wd_wait", 0,1,0,3'bxxx,3'b101,8'h99, S_REQ,  0,0,8'h00);
    step("wd_drop", 0,0,0,3'bxxx,3'b101,8'h99, S_ACT,  0,0,8'h00);
    // system token changed after START is ignored
    step("tl_req",  0,1,0,3'b000,3'b010,8'h00, S_REQ,  0,0,8'h00);
    step("tl_cf",   0,1,1,3'b101,3'b010,8'hAA, S_P,    1,0,8'hAA);
    step("tl_end",  0,0,0,3'b101,3'b010,8'hAA, S_ACT,  0,0,8'h00);
    // reset mid-store, then re-latch 010
    step("rm_req",  0,1,0,3'b000,3'b010,8'h00, S_REQ,  0,0,8'h00);
    step("rm_cf",   0,1,1,3'b101,3'b010,8'h55, S_P,    1,0,8'h55);
    step("rm_rst",  1,1,1,3'b101,3'b010,8'h55, S_START,0,0,8'h00);
    step("rm_strt", 0,0,0,3'b101,3'b010,8'h55, S_ACT,  0,0,8'h00);
    step("rl_req",  0,1,0,3'b000,3'b111,8'h00, S_REQ,  0,0,8'h00);
    step("rl_cf",   0,1,1,3'b101,3'b111,8'h66, S_Q,    0,1,8'h66);
    step("rl_end",  0,0,0,3'b101,3'b111,8'h66, S_ACT,  0,0,8'h00);
    // token value 0 is valid
    step("z_rst",   1,0,0,3'b000,3'b000,8'h00, S_START,0,0,8'h00);
    step("z_strt",  0,0,0,3'b000,3'b000,8'h00, S_ACT,  0,0,8'h00);
    step("z_req",   0,1,0,3'b000,3'b000,8'h00, S_REQ,  0,0,8'h00);
    step("z_cf",    0,1,1,3'b000,3'b000,8'h42, S_P,    1,0,8'h42);
    step("z_end",   0,1,0,3'b000,3'b000,8'h42, S_ACT,  0,0,8'h00);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
